// File: rtl/booth_div_seq.sv
// Sequential signed restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quot/rem.
// One trial subtraction per cycle on magnitudes, with sign fix-up, saturation and flags in a final cycle.
module booth_div_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic [W-1:0]     quot,
    output logic [W-1:0]     rem,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             ovf
);
    // state  | meaning
    // IDLE   | holding last result, waiting for start
    // ITER   | one shift/trial-subtract per cycle, W cycles
    // FIX    | apply signs, saturate, raise flags, pulse done
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W:0]      rem_acc_q, rem_acc_d;
    logic [W-1:0]    q_acc_q, q_acc_d;
    logic [W-1:0]    dsr_q, dsr_d;
    logic [W-1:0]    dvd_lo_q, dvd_lo_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;
    logic            uovf_q, uovf_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            done_q, done_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;

    logic [2*W-1:0]  abs_dvd;
    logic [W-1:0]    abs_dsr;
    logic [W:0]      r_sh;
    logic            ge;
    logic            ovf_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_ITER;
        end else begin
            case (state_q)
                S_ITER:  if (count_q == CW'(W - 1)) state_d = S_FIX;
                S_FIX:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        abs_dvd = dividend[2*W-1] ? -dividend : dividend;
        abs_dsr = divisor[W-1] ? -divisor : divisor;
        r_sh    = {rem_acc_q[W-1:0], q_acc_q[W-1]};
        ge      = (r_sh >= {1'b0, dsr_q});
        // rem_acc_q[W] can only be set when the dividend's upper half already overflowed
        ovf_fix = uovf_q | rem_acc_q[W] |
                  (neg_quot_q ? (q_acc_q > MIN_NEG) : (q_acc_q > MAX_POS));

        count_d    = count_q;
        rem_acc_d  = rem_acc_q;
        q_acc_d    = q_acc_q;
        dsr_d      = dsr_q;
        dvd_lo_d   = dvd_lo_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        uovf_d     = uovf_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        if (start) begin
            count_d    = '0;
            rem_acc_d  = {1'b0, abs_dvd[2*W-1:W]};
            q_acc_d    = abs_dvd[W-1:0];
            dsr_d      = abs_dsr;
            dvd_lo_d   = dividend[W-1:0];
            neg_quot_d = dividend[2*W-1] ^ divisor[W-1];
            neg_rem_d  = dividend[2*W-1];
            dz_d       = (divisor == '0);
            uovf_d     = (abs_dvd[2*W-1:W] >= abs_dsr);
        end else begin
            case (state_q)
                S_ITER: begin
                    rem_acc_d = ge ? (r_sh - {1'b0, dsr_q}) : r_sh;
                    q_acc_d   = {q_acc_q[W-2:0], ge};
                    count_d   = count_q + CW'(1);
                end
                S_FIX: begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        quot_d     = neg_rem_q ? MIN_NEG : MAX_POS;
                        rem_d      = dvd_lo_q;
                        div_zero_d = 1'b1;
                        ovf_d      = 1'b0;
                    end else if (ovf_fix) begin
                        quot_d     = neg_quot_q ? MIN_NEG : MAX_POS;
                        rem_d      = '0;
                        div_zero_d = 1'b0;
                        ovf_d      = 1'b1;
                    end else begin
                        quot_d     = neg_quot_q ? -q_acc_q : q_acc_q;
                        rem_d      = neg_rem_q ? -rem_acc_q[W-1:0] : rem_acc_q[W-1:0];
                        div_zero_d = 1'b0;
                        ovf_d      = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            rem_acc_q  <= '0;
            q_acc_q    <= '0;
            dsr_q      <= '0;
            dvd_lo_q   <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            uovf_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            rem_acc_q  <= rem_acc_d;
            q_acc_q    <= q_acc_d;
            dsr_q      <= dsr_d;
            dvd_lo_q   <= dvd_lo_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            uovf_q     <= uovf_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = done_q;
        quot     = quot_q;
        rem      = rem_q;
        div_zero = div_zero_q;
        ovf      = ovf_q;
    end

endmodule
